// File: rtl/fifo_buffer.sv
// Parametrised single-clock FIFO with occupancy count, registered read port and watermark flags.
// Define FIFO_ERR_STICKY_EN to make overflow/underflow sticky until reset; otherwise they are one-cycle pulses.
module fifo_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    localparam int AW        = $clog2(DEPTH),
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [AW:0]           count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] ZERO_C  = {(AW+1){1'b0}};
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  rd_acc_s;
    logic                  wr_acc_s;
    logic                  ovf_evt_s;
    logic                  udf_evt_s;
    logic                  full_s;
    logic                  empty_s;

    // Status flags decode only the registered count, never the requests.
    always_comb begin
        full_s       = (count_q == DEPTH_C);
        empty_s      = (count_q == ZERO_C);
        almost_full  = (count_q >= AF_C);
        almost_empty = (count_q <= AE_C);
    end

    // Accept logic and next-state for pointers, count, read port and error flags.
    always_comb begin
        rd_acc_s    = rd_en && !empty_s;
        wr_acc_s    = wr_en && (!full_s || rd_acc_s);
        ovf_evt_s   = wr_en && !wr_acc_s;
        udf_evt_s   = rd_en && empty_s;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d   = rd_ptr_q + ONE_C;
            rd_data_d  = mem_q[rd_ptr_q[AW-1:0]];
            rd_valid_d = 1'b1;
        end else begin
            rd_ptr_d   = rd_ptr_q;
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
        end

        if (wr_acc_s && !rd_acc_s) begin
            count_d = count_q + ONE_C;
        end else if (rd_acc_s && !wr_acc_s) begin
            count_d = count_q - ONE_C;
        end else begin
            count_d = count_q;
        end

`ifdef FIFO_ERR_STICKY_EN
        overflow_d  = overflow_q  | ovf_evt_s;
        underflow_d = underflow_q | udf_evt_s;
`else
        overflow_d  = ovf_evt_s;
        underflow_d = udf_evt_s;
`endif
    end

    // Control and read-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= ZERO_C;
            rd_ptr_q    <= ZERO_C;
            count_q     <= ZERO_C;
            rd_data_q   <= {DATA_WIDTH{1'b0}};
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is left unreset; the pointers guarantee unwritten entries are never read.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign full      = full_s;
    assign empty     = empty_s;
    assign count     = count_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed self-checking bench for fifo_buffer at DEPTH=32, DATA_WIDTH=8.
// Error-flag expectations follow FIFO_ERR_STICKY_EN when it is defined for the build.
module tb_fifo_buffer;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [5:0] count;
    logic       overflow;
    logic       underflow;

    int n_checks;
    int n_pass;

`ifdef FIFO_ERR_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    fifo_buffer #(
        .DATA_WIDTH(8),
        .DEPTH(32),
        .AF_THRESH(30),
        .AE_THRESH(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_plain(input logic [7:0] base);
        for (int i = 1; i <= 32; i++) begin
            wr_en   = 1'b1;
            wr_data = base + 8'(i);
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] got;
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
        step();
        step();
        got = {count, empty, almost_empty, full, almost_full, rd_valid, overflow, underflow, 1'b0};
        n_checks++;
        if (got !== {6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_flags got=%b exp=%b", got, {6'd0, 8'b11000000});
        else n_pass++;
        n_checks++;
        if (rd_data !== 8'h00) $display("FAIL reset_rd_data got=%h exp=00", rd_data);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 32; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            step();
            n_checks++;
            if (count !== 6'(i) || empty !== 1'b0 || full !== (i == 32) ||
                almost_full !== (i >= 30) || almost_empty !== (i <= 2))
                $display("FAIL fill[%0d] count=%0d e=%b f=%b af=%b ae=%b", i, count, empty, full, almost_full, almost_empty);
            else n_pass++;
        end
        wr_en = 1'b0;
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 32; i++) begin
            rd_en = 1'b1;
            step();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(i) || count !== 6'(32 - i))
                $display("FAIL drain[%0d] valid=%b data=%h count=%0d exp data=%h count=%0d", i, rd_valid, rd_data, count, 8'(i), 32 - i);
            else n_pass++;
        end
        rd_en = 1'b0;
        step();
        n_checks++;
        if (rd_valid !== 1'b0 || empty !== 1'b1 || count !== 6'd0 || rd_data !== 8'h20)
            $display("FAIL drain_end valid=%b empty=%b count=%0d data=%h exp 0/1/0/20", rd_valid, empty, count, rd_data);
        else n_pass++;
    endtask

    task automatic test_full_rw();
        logic [7:0] exp_v;
        fill_plain(8'h00);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hAA;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++;
        if (count !== 6'd32 || full !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 8'h01 || overflow !== 1'b0)
            $display("FAIL full_rw count=%0d full=%b valid=%b data=%h ovf=%b exp 32/1/1/01/0", count, full, rd_valid, rd_data, overflow);
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            rd_en = 1'b1;
            exp_v = (i < 31) ? 8'(i + 2) : 8'hAA;
            step();
            n_checks++;
            if (rd_data !== exp_v || rd_valid !== 1'b1 || count !== 6'(31 - i))
                $display("FAIL full_rw_drain[%0d] data=%h valid=%b count=%0d exp %h", i, rd_data, rd_valid, count, exp_v);
            else n_pass++;
        end
        rd_en = 1'b0;
        step();
    endtask

    task automatic test_empty_rw();
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h55;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++;
        if (count !== 6'd1 || rd_valid !== 1'b0 || underflow !== 1'b1 || rd_data !== 8'hAA || empty !== 1'b0)
            $display("FAIL empty_rw count=%0d valid=%b udf=%b data=%h empty=%b exp 1/0/1/aa/0", count, rd_valid, underflow, rd_data, empty);
        else n_pass++;
        step();
        n_checks++;
        if (underflow !== STICKY || count !== 6'd1)
            $display("FAIL empty_rw_udf_after udf=%b count=%0d exp %b/1", underflow, count, STICKY);
        else n_pass++;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        n_checks++;
        if (rd_data !== 8'h55 || rd_valid !== 1'b1 || count !== 6'd0)
            $display("FAIL empty_rw_read data=%h valid=%b count=%0d exp 55/1/0", rd_data, rd_valid, count);
        else n_pass++;
        step();
    endtask

    task automatic test_overflow();
        fill_plain(8'h40);
        wr_en = 1'b1; wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        n_checks++;
        if (count !== 6'd32 || overflow !== 1'b1 || full !== 1'b1)
            $display("FAIL overflow count=%0d ovf=%b full=%b exp 32/1/1", count, overflow, full);
        else n_pass++;
        step();
        n_checks++;
        if (overflow !== STICKY)
            $display("FAIL overflow_after ovf=%b exp %b", overflow, STICKY);
        else n_pass++;
        for (int i = 1; i <= 15; i++) begin
            rd_en = 1'b1;
            step();
            n_checks++;
            if (rd_data !== 8'(8'h40 + 8'(i)) || count !== 6'(32 - i))
                $display("FAIL overflow_contents[%0d] data=%h count=%0d exp %h/%0d", i, rd_data, count, 8'(8'h40 + 8'(i)), 32 - i);
            else n_pass++;
        end
        rd_en = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        logic [12:0] got;
        #1;
        rst_n = 1'b0;
        #1;
        got = {count, empty, almost_empty, full, almost_full, rd_valid, overflow, underflow};
        n_checks++;
        if (got !== {6'd0, 7'b1100000})
            $display("FAIL async_reset got=%b exp=%b", got, {6'd0, 7'b1100000});
        else n_pass++;
        n_checks++;
        if (rd_data !== 8'h00) $display("FAIL async_reset_rd_data got=%h exp=00", rd_data);
        else n_pass++;
        rst_n = 1'b1;
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h77;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++;
        if (count !== 6'd1 || rd_valid !== 1'b0 || underflow !== 1'b1)
            $display("FAIL post_reset_rw count=%0d valid=%b udf=%b exp 1/0/1", count, rd_valid, underflow);
        else n_pass++;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        n_checks++;
        if (rd_data !== 8'h77 || rd_valid !== 1'b1 || empty !== 1'b1)
            $display("FAIL post_reset_read data=%h valid=%b empty=%b exp 77/1/1", rd_data, rd_valid, empty);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_fill();
        test_drain();
        test_full_rw();
        test_empty_rw();
        test_overflow();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_buffer.md
# fifo_buffer

Parametrised synchronous FIFO for buffering butterfly-stage operands between producer and consumer datapaths on a single clock. It replaces the fixed 8-bit/32-entry array with configurable width, depth and watermark thresholds, adds an occupancy count, a registered read port with a valid strobe, defined simultaneous read/write behaviour at full and empty, and overflow/underflow error reporting.

## Interface
- DATA_WIDTH, 8, width of the data word.
- DEPTH, 32, number of entries; power of two, at least 4.
- AW, $clog2(DEPTH), address width; derived, never overridden.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; range 1..DEPTH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data, sampled when a write is accepted.
- rd_en  in  1  read request.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  one-cycle strobe; rd_data holds a newly popped word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  write rejected (see Configuration).
- underflow  out  1  read rejected (see Configuration).

## Operation
- State: wr_ptr and rd_ptr, each AW+1 bits (MSB is the wrap bit), registered count (AW+1 bits), rd_data, rd_valid and the error flags.
- Storage array is not reset; an unwritten entry is never read.
- Read accept: rd_acc = rd_en && !empty.
- Write accept: wr_acc = wr_en && (!full || rd_acc). At full, a write is accepted only in the same cycle as an accepted read.
- On wr_acc: mem[wr_ptr[AW-1:0]] <= wr_data; wr_ptr increments, wrapping modulo 2*DEPTH.
- On rd_acc: rd_data <= mem[rd_ptr[AW-1:0]] (value before any same-edge write); rd_ptr increments; rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds its value.
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
- Simultaneous read and write at empty: the write is accepted and the read rejected (underflow). The FIFO never bypasses wr_data to rd_data.
- Simultaneous read and write at full: both are accepted; count stays DEPTH.
- full, empty, almost_full and almost_empty are combinational decodes of the registered count only; they have no combinational path from wr_en or rd_en.
- Rejected write (wr_en && !wr_acc) raises the overflow event; rejected read (rd_en && empty) raises the underflow event. Neither changes pointers, count or memory.

## Timing
- Reset (rst_n low, asynchronous): pointers 0, count 0, rd_data 0, rd_valid 0, overflow 0, underflow 0, empty 1, almost_empty 1, full 0, almost_full 0 (1 only if AF_THRESH == 0, which is illegal).
- Reset asserted mid-operation clears all contents logically in the same cycle; the first post-reset edge behaves as from an empty FIFO.
- Write-to-flag latency: a write accepted at edge N updates count, empty and the watermarks after edge N.
- Read latency: rd_en accepted at edge N gives rd_data and rd_valid after edge N; rd_valid lasts one cycle per pop.
- Write-to-read-data latency, minimum 2 edges: write at edge N, read accepted at edge N+1, data after edge N+1.
- Sustained throughput: one write and one read per cycle at any occupancy 1..DEPTH.

## Configuration
- FIFO_ERR_STICKY_EN defined: overflow and underflow are sticky. Each sets on its event and holds 1 until rst_n is asserted.
- FIFO_ERR_STICKY_EN undefined: overflow and underflow are registered single-cycle pulses. Each is 1 in the cycle after its event and 0 otherwise.
- In both builds the ports are present and behave identically otherwise.

## Test plan
- Reset, then write 0x01..0x20 on 32 consecutive cycles (DEPTH=32) -> count 32, full=1, almost_full rises when count reaches 30, empty falls after the first edge.
- From full, read 32 times -> rd_data 0x01..0x20 in order, each with a one-cycle rd_valid strobe one edge after rd_en; empty=1 and count=0 at the end.
- At full, drive wr_en=rd_en=1 with wr_data=0xAA -> the oldest word is popped, count stays 32, and 0xAA appears as the last word of a subsequent drain.
- At empty, drive wr_en=rd_en=1 with wr_data=0x55 -> count 1, rd_valid 0, underflow asserted. Next read returns 0x55.
- Write while full with no read -> count stays 32, contents unchanged, overflow asserted: sticky until reset with FIFO_ERR_STICKY_EN, a single-cycle pulse without it.
- Assert rst_n low for less than one cycle with count=17 -> all outputs return to their reset values immediately, with no clock edge required.
